// File: rtl/ssd_scan_controller.sv
// Multiplexed seven-segment scan controller with frame-synchronous double buffering.
// Optional macro LEADING_ZERO_BLANK_EN suppresses the segments of leading zero digits.
module ssd_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    En,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DPMask,
  output logic [7:0]              SSD,
  output logic [NUM_DIGITS-1:0]   DigitSel,
  output logic                    FrameTick
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CntLast   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BlankLast = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic                    frame_end;
  logic [7:0]              ssd_d;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic                    tick_d;
  logic [6:0]              seg;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    hexseg = 7'h00;
    case (n)
      4'h0: hexseg = 7'h3F;
      4'h1: hexseg = 7'h06;
      4'h2: hexseg = 7'h5B;
      4'h3: hexseg = 7'h4F;
      4'h4: hexseg = 7'h66;
      4'h5: hexseg = 7'h6D;
      4'h6: hexseg = 7'h7D;
      4'h7: hexseg = 7'h07;
      4'h8: hexseg = 7'h7F;
      4'h9: hexseg = 7'h6F;
      4'hA: hexseg = 7'h77;
      4'hB: hexseg = 7'h7C;
      4'hC: hexseg = 7'h39;
      4'hD: hexseg = 7'h5E;
      4'hE: hexseg = 7'h79;
      4'hF: hexseg = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (En) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      StBlank: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BlankLast) state_d = StShow;
      end
      StShow: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StBlank;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (!En) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  // Commit happens at the end of the last show cycle of a frame, even if En drops then.
  assign frame_end = (state_q == StShow) && (idx_q == IdxLast) && (cnt_q == CntLast);

  always_comb begin
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    if (state_q == StIdle) begin
      if (Load) begin
        active_val_d = Value;
        active_dp_d  = DPMask;
      end
    end else if (frame_end) begin
      if (Load) begin
        active_val_d = Value;
        active_dp_d  = DPMask;
      end else if (pend_flag_q) begin
        active_val_d = pend_val_q;
        active_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (Load) begin
      pend_val_d  = Value;
      pend_dp_d   = DPMask;
      pend_flag_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (active_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end
`endif

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    ssd_d  = '0;
    sel_d  = '0;
    tick_d = 1'b0;
    seg    = hexseg(active_val_q[4*idx_d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if (lz_mask[idx_d]) seg = 7'h00;
`endif
    if (state_d == StShow) begin
      sel_d[idx_d] = 1'b1;
      ssd_d        = {active_dp_q[idx_d], seg};
      tick_d       = (idx_d == IdxLast) && (cnt_d == CntLast);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      SSD          <= '0;
      DigitSel     <= '0;
      FrameTick    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      SSD          <= ssd_d;
      DigitSel     <= sel_d;
      FrameTick    <= tick_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Randomised and directed bench for ssd_scan_controller against a frame-position model.
// Honours LEADING_ZERO_BLANK_EN in the model and adds a directed test when it is defined.
module tb_ssd_scan_controller;
  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = N * R;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        En = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;
  logic [3:0]  DPMask = '0;
  logic [7:0]  SSD;
  logic [3:0]  DigitSel;
  logic        FrameTick;

  ssd_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Load(Load), .Value(Value), .DPMask(DPMask),
    .SSD(SSD), .DigitSel(DigitSel), .FrameTick(FrameTick)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: scan position is one integer t counting cycles into the frame.
  bit          m_scan;
  int          m_t;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pf;

  task automatic tick(input bit rst, input bit en, input bit ld, input logic [15:0] v,
                      input logic [3:0] dp);
    bit fe;
    Rst = rst; En = en; Load = ld; Value = v; DPMask = dp;
    @(posedge Clk);
    if (rst) begin
      m_scan = 0; m_t = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pf = 0;
    end else begin
      fe = m_scan && (m_t == F - 1);
      if (!m_scan) begin
        if (ld) begin m_val = v; m_dp = dp; end
      end else if (fe) begin
        if (ld) begin m_val = v; m_dp = dp; end
        else if (m_pf) begin m_val = m_pval; m_dp = m_pdp; end
        m_pf = 0;
      end else if (ld) begin
        m_pval = v; m_pdp = dp; m_pf = 1;
      end
      if (!en) begin m_scan = 0; m_t = 0; end
      else if (!m_scan) begin m_scan = 1; m_t = 0; end
      else m_t = (m_t + 1) % F;
    end
    #1;
  endtask

  function automatic bit showing();
    return m_scan && ((m_t % R) >= B);
  endfunction

  function automatic logic [12:0] expected();
    int d;
    logic [6:0] s;
    if (!showing()) return {8'h00, 4'h0, 1'b0};
    d = m_t / R;
    s = seg_tab[m_val[4*d +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (m_val >> (4 * d)) == 16'h0) s = 7'h00;
`endif
    return {m_dp[d], s, 4'(1 << d), (m_t == F - 1)};
  endfunction

  task automatic test_reset();
    tick(1, 0, 0, 16'hFFFF, 4'hF);
    tick(1, 1, 1, 16'hFFFF, 4'hF);
    vectors++;
    if ({SSD, DigitSel, FrameTick} !== 13'h0) begin
      errors++;
      $display("FAIL reset: got ssd=%h sel=%b ft=%b, want all zero", SSD, DigitSel, FrameTick);
    end
  endtask

  task automatic test_basic();
    logic [6:0] want [4] = '{7'h71, 7'h77, 7'h5B, 7'h06};
    tick(0, 0, 1, 16'h12AF, 4'h0);
    for (int k = 0; k < 2 * F; k++) begin
      tick(0, 1, 0, 16'h0, 4'h0);
      vectors++;
      if ({SSD, DigitSel, FrameTick} !== expected()) begin
        errors++;
        $display("FAIL basic_model k=%0d: got %h/%b/%b want %h", k, SSD, DigitSel, FrameTick,
                 expected());
      end
      if (k % R == B) begin
        vectors++;
        if (DigitSel !== 4'(1 << ((k / R) % N)) || SSD !== {1'b0, want[(k / R) % N]}) begin
          errors++;
          $display("FAIL basic_digit k=%0d: got sel=%b ssd=%h want sel=%b ssd=%h", k, DigitSel,
                   SSD, 4'(1 << ((k / R) % N)), want[(k / R) % N]);
        end
      end
      if ((k % R) < B) begin
        vectors++;
        if (DigitSel !== 4'b0) begin
          errors++;
          $display("FAIL basic_blank k=%0d: got sel=%b want 0000", k, DigitSel);
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    bit seen_tick = 0;
    for (int k = 0; k < 2 * F; k++) begin
      tick(0, 1, (k == 10), 16'h0000, 4'h0);
      vectors++;
      if ({SSD, DigitSel, FrameTick} !== expected()) begin
        errors++;
        $display("FAIL midload_model k=%0d: got %h/%b/%b want %h", k, SSD, DigitSel, FrameTick,
                 expected());
      end
      if (DigitSel != 4'b0) begin
        vectors++;
        if (seen_tick ? (SSD[6:0] !== 7'h3F) : (SSD[6:0] === 7'h3F)) begin
          errors++;
          $display("FAIL midload_tear k=%0d: got ssd=%h committed=%0d", k, SSD, seen_tick);
        end
      end
      if (FrameTick) seen_tick = 1;
    end
  endtask

  task automatic test_dp();
    bit done = 0;
    tick(0, 1, 1, 16'h12AF, 4'b0100);
    for (int k = 0; k < 2 * F && !done; k++) begin
      tick(0, 1, 0, 16'h0, 4'h0);
      if (FrameTick) done = 1;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL dp_wait: got no FrameTick within %0d cycles, want one", 2 * F);
    end
    for (int k = 0; k < F; k++) begin
      tick(0, 1, 0, 16'h0, 4'h0);
      vectors++;
      if (SSD[7] !== (DigitSel == 4'b0100) || {SSD, DigitSel, FrameTick} !== expected()) begin
        errors++;
        $display("FAIL dp k=%0d: got ssd=%h sel=%b want %h", k, SSD, DigitSel, expected());
      end
    end
  endtask

  task automatic test_en_drop();
    bit found = 0;
    for (int k = 0; k < 2 * F && !found; k++) begin
      tick(0, 1, 0, 16'h0, 4'h0);
      if (DigitSel == 4'b0100) found = 1;
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL endrop_wait: got no digit 2 within %0d cycles, want one", 2 * F);
    end
    tick(0, 0, 0, 16'h0, 4'h0);
    vectors++;
    if (SSD !== 8'h0 || DigitSel !== 4'h0 || FrameTick !== 1'b0) begin
      errors++;
      $display("FAIL endrop_idle: got ssd=%h sel=%b ft=%b want zeros", SSD, DigitSel, FrameTick);
    end
    tick(0, 0, 0, 16'h0, 4'h0);
    for (int k = 0; k <= B; k++) begin
      tick(0, 1, 0, 16'h0, 4'h0);
      vectors++;
      if (DigitSel !== ((k == B) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL endrop_restart k=%0d: got sel=%b want %b", k, DigitSel,
                 (k == B) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_rst_midframe();
    for (int k = 0; k < 13; k++) tick(0, 1, 0, 16'h0, 4'h0);
    tick(1, 1, 0, 16'h0, 4'h0);
    vectors++;
    if ({SSD, DigitSel, FrameTick} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid: got ssd=%h sel=%b ft=%b want zeros", SSD, DigitSel, FrameTick);
    end
    for (int k = 0; k <= B; k++) tick(0, 1, 0, 16'h0, 4'h0);
    vectors++;
    if (SSD !== 8'h3F || DigitSel !== 4'b0001) begin
      errors++;
      $display("FAIL rst_restart: got ssd=%h sel=%b want 3f/0001", SSD, DigitSel);
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    logic [6:0] want_a [4] = '{7'h3F, 7'h6D, 7'h00, 7'h00};
    logic [6:0] want_b [4] = '{7'h3F, 7'h00, 7'h00, 7'h00};
    for (int pass = 0; pass < 2; pass++) begin
      tick(0, 0, 0, 16'h0, 4'h0);
      tick(0, 0, 1, (pass == 0) ? 16'h0050 : 16'h0000, 4'h0);
      for (int k = 0; k < F; k++) begin
        tick(0, 1, 0, 16'h0, 4'h0);
        if (k % R == B) begin
          vectors++;
          if (SSD[6:0] !== ((pass == 0) ? want_a[k / R] : want_b[k / R])) begin
            errors++;
            $display("FAIL lzb pass=%0d digit=%0d: got %h want %h", pass, k / R, SSD[6:0],
                     (pass == 0) ? want_a[k / R] : want_b[k / R]);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    bit en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) en = !en;
      tick(($urandom_range(0, 299) == 0), en, ($urandom_range(0, 9) == 0),
           16'($urandom), 4'($urandom));
      vectors++;
      if ({SSD, DigitSel, FrameTick} !== expected()) begin
        errors++;
        $display("FAIL random k=%0d: got %h/%b/%b want %h", k, SSD, DigitSel, FrameTick,
                 expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_load();
    test_dp();
    test_en_drop();
    test_rst_midframe();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
